// File: rtl/l2cache_req_arbiter_pkg.sv
// Shared encodings for the L2 request arbiter: request source codes, FSM states,
// transaction owners and the latched request payload.
package l2cache_req_arbiter_pkg;

  localparam logic [1:0] FROM_OP_PREF = 2'd0;
  localparam logic [1:0] FROM_I       = 2'd1;
  localparam logic [1:0] FROM_DR      = 2'd2;
  localparam logic [1:0] FROM_DW      = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ISSUE     = 2'd1,
    ST_WAIT_DATA = 2'd2,
    ST_WAIT_ACK  = 2'd3
  } arb_state_e;

  typedef enum logic [2:0] {
    OWNER_NONE = 3'd0,
    OWNER_OP   = 3'd1,
    OWNER_D    = 3'd2,
    OWNER_I    = 3'd3,
    OWNER_P    = 3'd4
  } arb_owner_e;

  typedef struct packed {
    logic        opflag;
    logic [31:0] opcode;
    logic [1:0]  from;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [1:0]  size;
    logic        suc;
  } l2_payload_t;

endpackage

// File: rtl/l2cache_req_arbiter_age_cnt.sv
// Saturating aging counter: counts lost arbitrations of one requester,
// cleared when that requester is granted.
module l2arb_age_cnt #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             inc_i,
  input  logic             clr_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)
      cnt_d = '0;
    else if (inc_i && (cnt_q != '1))
      cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!rstn)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/l2cache_req_arbiter.sv
// Arbitrates the single L2 request port between cache-op pipe, Dcache, Icache and
// prefetcher with a registered grant and aging, and tracks the one outstanding transaction.
module l2cache_req_arbiter
  import l2cache_req_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 8,
  parameter int CNT_W        = 4
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        op_req_i,
  input  logic [31:0] op_code_i,
  input  logic [31:0] op_addr_i,
  output logic        op_ack_o,
  input  logic        d_req_i,
  input  logic        d_wr_i,
  input  logic [31:0] d_addr_i,
  input  logic [31:0] d_wdata_i,
  input  logic [3:0]  d_wstrb_i,
  input  logic [1:0]  d_size_i,
  input  logic        d_suc_i,
  output logic        d_addr_ok_o,
  output logic        d_data_ok_o,
  input  logic        i_req_i,
  input  logic [31:0] i_addr_i,
  input  logic        i_flush_i,
  output logic        i_addr_ok_o,
  output logic        i_data_ok_o,
  input  logic        p_req_i,
  input  logic [31:0] p_addr_i,
  output logic        p_addr_ok_o,
  output logic        p_done_o,
  output logic        l2_req_o,
  output logic [1:0]  l2_from_o,
  output logic        l2_opflag_o,
  output logic [31:0] l2_opcode_o,
  output logic [31:0] l2_addr_o,
  output logic [31:0] l2_wdata_o,
  output logic [3:0]  l2_wstrb_o,
  output logic [1:0]  l2_size_o,
  output logic        l2_suc_o,
  input  logic        l2_addr_ok_i,
  input  logic        l2_data_ok_i,
  input  logic        l2_ack_op_i
);

  localparam logic [CNT_W-1:0] AGE_LIMIT = CNT_W'(STARVE_LIMIT);

  arb_state_e  state_q, state_d;
  arb_owner_e  owner_q, owner_d;
  arb_owner_e  win;
  l2_payload_t pay_q, pay_d;
  logic        drop_q, drop_d;
  logic        d_aok_q, i_aok_q, p_aok_q;
  logic        grant;
  logic        i_inc, i_clr, p_inc, p_clr;
  logic [CNT_W-1:0] i_age, p_age;

  // A starved requester (I first, then pref) is promoted above D but never above op.
  always_comb begin
    win = OWNER_NONE;
    if (op_req_i)                            win = OWNER_OP;
    else if (i_req_i && (i_age >= AGE_LIMIT)) win = OWNER_I;
    else if (p_req_i && (p_age >= AGE_LIMIT)) win = OWNER_P;
    else if (d_req_i)                        win = OWNER_D;
    else if (i_req_i)                        win = OWNER_I;
    else if (p_req_i)                        win = OWNER_P;
  end

  assign grant = (state_q == ST_IDLE) && (win != OWNER_NONE);
  assign i_clr = grant && (win == OWNER_I);
  assign i_inc = grant && i_req_i && (win != OWNER_I);
  assign p_clr = grant && (win == OWNER_P);
  assign p_inc = grant && p_req_i && (win != OWNER_P);

  l2arb_age_cnt #(.CNT_W(CNT_W)) u_i_age (
    .clk   (clk),
    .rstn  (rstn),
    .inc_i (i_inc),
    .clr_i (i_clr),
    .cnt_o (i_age)
  );

  l2arb_age_cnt #(.CNT_W(CNT_W)) u_p_age (
    .clk   (clk),
    .rstn  (rstn),
    .inc_i (p_inc),
    .clr_i (p_clr),
    .cnt_o (p_age)
  );

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= ST_IDLE;
      owner_q <= OWNER_NONE;
      pay_q   <= '0;
      drop_q  <= 1'b0;
      d_aok_q <= 1'b0;
      i_aok_q <= 1'b0;
      p_aok_q <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      pay_q   <= pay_d;
      drop_q  <= drop_d;
      d_aok_q <= grant && (win == OWNER_D);
      i_aok_q <= grant && (win == OWNER_I);
      p_aok_q <= grant && (win == OWNER_P);
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:      if (grant) state_d = ST_ISSUE;
      ST_ISSUE:     if (l2_addr_ok_i)
                      state_d = (owner_q == OWNER_OP) ? ST_WAIT_ACK : ST_WAIT_DATA;
      ST_WAIT_DATA: if (l2_data_ok_i) state_d = ST_IDLE;
      ST_WAIT_ACK:  if (l2_ack_op_i)  state_d = ST_IDLE;
      default:      state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    owner_d = owner_q;
    pay_d   = pay_q;
    drop_d  = drop_q;
    if (grant) begin
      owner_d = win;
      pay_d   = '0;
      case (win)
        OWNER_OP: begin
          pay_d.opflag = 1'b1;
          pay_d.opcode = op_code_i;
          pay_d.addr   = op_addr_i;
          pay_d.from   = FROM_OP_PREF;
        end
        OWNER_D: begin
          pay_d.from  = d_wr_i ? FROM_DW : FROM_DR;
          pay_d.addr  = d_addr_i;
          pay_d.wdata = d_wdata_i;
          pay_d.wstrb = d_wstrb_i;
          pay_d.size  = d_size_i;
          pay_d.suc   = d_suc_i;
        end
        OWNER_I: begin
          pay_d.from = FROM_I;
          pay_d.addr = i_addr_i;
        end
        OWNER_P: begin
          pay_d.from = FROM_OP_PREF;
          pay_d.addr = p_addr_i;
        end
        default: ;
      endcase
    end
    if (i_flush_i && (owner_q == OWNER_I) &&
        ((state_q == ST_ISSUE) || (state_q == ST_WAIT_DATA)))
      drop_d = 1'b1;
    if (state_d == ST_IDLE) begin
      owner_d = OWNER_NONE;
      drop_d  = 1'b0;
    end
  end

  always_comb begin
    l2_req_o    = (state_q == ST_ISSUE);
    l2_from_o   = pay_q.from;
    l2_opflag_o = pay_q.opflag;
    l2_opcode_o = pay_q.opcode;
    l2_addr_o   = pay_q.addr;
    l2_wdata_o  = pay_q.wdata;
    l2_wstrb_o  = pay_q.wstrb;
    l2_size_o   = pay_q.size;
    l2_suc_o    = pay_q.suc;
    d_addr_ok_o = d_aok_q;
    i_addr_ok_o = i_aok_q;
    p_addr_ok_o = p_aok_q;
    d_data_ok_o = (state_q == ST_WAIT_DATA) && (owner_q == OWNER_D) && l2_data_ok_i;
    i_data_ok_o = (state_q == ST_WAIT_DATA) && (owner_q == OWNER_I) && l2_data_ok_i
                  && !drop_q && !i_flush_i;
    p_done_o    = (state_q == ST_WAIT_DATA) && (owner_q == OWNER_P) && l2_data_ok_i;
    op_ack_o    = (state_q == ST_WAIT_ACK) && (owner_q == OWNER_OP) && l2_ack_op_i;
  end

endmodule
